// File: rtl/bus_memory.sv
// -----------------------------------------------------------------------------
// bus_memory
//   Word-addressed memory responder for the CPU external memory bus. It answers
//   CPU reads by driving the shared 16-bit data bus, captures CPU writes, and
//   accepts program images from a host loader through a valid/ready handshake.
//   Saturating read/write counters aid bring-up.
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | serve CPU reads (wr=1) and writes (wr=0)
//   LOAD  | host loading at ptr; CPU bus ignored, data_bus released
//   DONE  | one-cycle end-of-session marker, ld_done asserted
//
// Ports
//   clk          system clock, shared with the CPU
//   reset        synchronous active-low reset
//   address_bus  CPU word address, only [ADDR_W-1:0] used (upper bits alias)
//   data_bus     bidirectional CPU data bus, driven only while servicing a read
//   wr           CPU strobe: 1 = read, 0 = write
//   ld_en        host requests load mode
//   ld_valid     host load word valid
//   ld_data      host load word
//   ld_ready     load word accepted this cycle (registered)
//   ld_done      one-cycle pulse when a load session ends
//   ld_count     words written in the current or last load session
//   rd_cnt       serviced CPU reads, saturating
//   wr_cnt       accepted CPU writes, saturating
// -----------------------------------------------------------------------------
module bus_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       address_bus,
    inout  wire  [15:0]       data_bus,
    input  logic              wr,
    input  logic              ld_en,
    input  logic              ld_valid,
    input  logic [15:0]       ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_ptr;
    logic                r_ld_ready;
    logic                r_ld_done;
    logic [15:0]         r_rd_cnt;
    logic [15:0]         r_wr_cnt;
    logic [15:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_addr;
    logic                w_cpu_rd;
    logic                w_cpu_wr;
    logic                w_ld_accept;
    logic [ADDR_W:0]     w_ptr_next;
    logic                w_unused_addr_hi;

    assign w_addr           = address_bus[ADDR_W-1:0];
    assign w_unused_addr_hi = ^address_bus[15:ADDR_W];

    // Reset gates the bus drive so the block stays off the bus while held.
    assign w_cpu_rd    = reset && (r_state == S_IDLE) && wr;
    assign w_cpu_wr    = reset && (r_state == S_IDLE) && !wr;
    assign w_ld_accept = reset && (r_state == S_LOAD) && ld_valid && r_ld_ready;
    assign w_ptr_next  = r_ptr + {{ADDR_W{1'b0}}, w_ld_accept};

    assign data_bus = w_cpu_rd ? r_mem[w_addr] : 16'bz;

    // Memory has no reset: preloaded images survive an aborted session.
    always_ff @(posedge clk) begin
        if (w_cpu_wr) begin
            r_mem[w_addr] <= data_bus;
        end else if (w_ld_accept) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b0;
            r_rd_cnt   <= 16'd0;
            r_wr_cnt   <= 16'd0;
        end else begin
            r_ld_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr) begin
                        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
                    end else begin
                        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                    if (ld_en) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_ptr <= w_ptr_next;
                    if (!ld_en) begin
                        r_state    <= S_DONE;
                        r_ld_ready <= 1'b0;
                        r_ld_done  <= 1'b1;
                    end else begin
                        // MSB of the pointer set means every word is filled.
                        r_ld_ready <= !w_ptr_next[ADDR_W];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready = r_ld_ready;
    assign ld_done  = r_ld_done;
    assign ld_count = r_ptr;
    assign rd_cnt   = r_rd_cnt;
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_bus_memory.sv
// -----------------------------------------------------------------------------
// tb_bus_memory
//   Directed bench for bus_memory. Instance A uses ADDR_W=8, instance B uses
//   ADDR_W=2 for the load-full boundary. Both data buses are pulled up, so a
//   released bus reads back as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_bus_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (ADDR_W=8)
    logic        a_reset, a_wr, a_ld_en, a_ld_valid, a_oe;
    logic [15:0] a_addr, a_ld_data, a_drv;
    tri1  [15:0] a_bus;
    logic        a_ld_ready, a_ld_done;
    logic [8:0]  a_ld_count;
    logic [15:0] a_rd_cnt, a_wr_cnt;

    assign a_bus = a_oe ? a_drv : 16'bz;

    bus_memory #(.ADDR_W(8)) u_a (
        .clk         (clk),
        .reset       (a_reset),
        .address_bus (a_addr),
        .data_bus    (a_bus),
        .wr          (a_wr),
        .ld_en       (a_ld_en),
        .ld_valid    (a_ld_valid),
        .ld_data     (a_ld_data),
        .ld_ready    (a_ld_ready),
        .ld_done     (a_ld_done),
        .ld_count    (a_ld_count),
        .rd_cnt      (a_rd_cnt),
        .wr_cnt      (a_wr_cnt)
    );

    // Instance B (ADDR_W=2)
    logic        b_reset, b_wr, b_ld_en, b_ld_valid;
    logic [15:0] b_addr, b_ld_data;
    tri1  [15:0] b_bus;
    logic        b_ld_ready, b_ld_done;
    logic [2:0]  b_ld_count;
    logic [15:0] b_rd_cnt, b_wr_cnt;

    bus_memory #(.ADDR_W(2)) u_b (
        .clk         (clk),
        .reset       (b_reset),
        .address_bus (b_addr),
        .data_bus    (b_bus),
        .wr          (b_wr),
        .ld_en       (b_ld_en),
        .ld_valid    (b_ld_valid),
        .ld_data     (b_ld_data),
        .ld_ready    (b_ld_ready),
        .ld_done     (b_ld_done),
        .ld_count    (b_ld_count),
        .rd_cnt      (b_rd_cnt),
        .wr_cnt      (b_wr_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        wr;
        logic [15:0] addr;
        logic        oe;
        logic [15:0] dq;
        logic        ld_en;
        logic        vld;
        logic [15:0] ldd;
        logic        chk_bus;
        logic [15:0] e_bus;
        logic        e_rdy;
        logic        e_done;
        logic [8:0]  e_cnt;
        logic [15:0] e_rd;
        logic [15:0] e_wr;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int offered;
        logic rdy;
        logic saw_done;

        //          rst wr addr     oe dq        en vld ldd       cb bus       rdy dn cnt rd     wr
        vecs[0]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'd0, 16'd0};
        vecs[1]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 16'h1111, 1, 16'hFFFF, 1, 0, 0, 16'd1, 16'd0};
        vecs[2]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 16'h2222, 1, 16'hFFFF, 1, 0, 1, 16'd1, 16'd0};
        vecs[3]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 0, 16'h9999, 1, 16'hFFFF, 1, 0, 2, 16'd1, 16'd0};
        vecs[4]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 16'h3333, 1, 16'hFFFF, 1, 0, 2, 16'd1, 16'd0};
        vecs[5]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 3, 16'd1, 16'd0};
        vecs[6]  = '{1, 1, 16'h0001, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 3, 16'd1, 16'd0};
        vecs[7]  = '{1, 1, 16'h0001, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h2222, 0, 0, 3, 16'd1, 16'd0};
        vecs[8]  = '{1, 1, 16'h0101, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h2222, 0, 0, 3, 16'd2, 16'd0};
        vecs[9]  = '{1, 1, 16'h0002, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3333, 0, 0, 3, 16'd3, 16'd0};
        vecs[10] = '{1, 0, 16'h0010, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 16'd4, 16'd0};
        vecs[11] = '{1, 1, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 0, 3, 16'd4, 16'd1};
        vecs[12] = '{1, 1, 16'h0110, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 0, 3, 16'd5, 16'd1};
        vecs[13] = '{1, 1, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1111, 0, 0, 3, 16'd6, 16'd1};
        vecs[14] = '{1, 0, 16'h0000, 1, 16'hDEAD, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'd7, 16'd1};
        vecs[15] = '{1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 0, 16'd7, 16'd1};
        vecs[16] = '{1, 1, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 0, 16'd7, 16'd1};
        vecs[17] = '{1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1111, 0, 0, 0, 16'd7, 16'd1};
        vecs[18] = '{1, 1, 16'h0002, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3333, 0, 0, 0, 16'd8, 16'd1};

        // Reset both instances for two edges.
        a_reset = 0; a_wr = 1; a_addr = 16'h0000; a_oe = 0; a_drv = 16'h0000;
        a_ld_en = 0; a_ld_valid = 0; a_ld_data = 16'h0000;
        b_reset = 0; b_wr = 1; b_addr = 16'h0000;
        b_ld_en = 0; b_ld_valid = 0; b_ld_data = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus",      a_bus, 16'hFFFF);
        chk("rst_ready",    {15'd0, a_ld_ready}, 16'd0);
        chk("rst_done",     {15'd0, a_ld_done}, 16'd0);
        chk("rst_count",    {7'd0, a_ld_count}, 16'd0);
        chk("rst_rd_cnt",   a_rd_cnt, 16'd0);
        chk("rst_wr_cnt",   a_wr_cnt, 16'd0);
        chk("rst_b_ready",  {15'd0, b_ld_ready}, 16'd0);
        chk("rst_b_bus",    b_bus, 16'hFFFF);
        @(posedge clk); #1;

        // Table: load, done pulse, aliasing reads, CPU write, isolation, re-entry gap.
        for (int i = 0; i < NV; i++) begin
            a_reset = vecs[i].rst;  a_wr = vecs[i].wr;  a_addr = vecs[i].addr;
            a_oe = vecs[i].oe;      a_drv = vecs[i].dq; a_ld_en = vecs[i].ld_en;
            a_ld_valid = vecs[i].vld; a_ld_data = vecs[i].ldd;
            @(negedge clk);
            if (vecs[i].chk_bus) chk($sformatf("v%0d_bus", i), a_bus, vecs[i].e_bus);
            chk($sformatf("v%0d_ready", i), {15'd0, a_ld_ready}, {15'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_done", i),  {15'd0, a_ld_done},  {15'd0, vecs[i].e_done});
            chk($sformatf("v%0d_count", i), {7'd0, a_ld_count},  {7'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_rd_cnt", i), a_rd_cnt, vecs[i].e_rd);
            chk($sformatf("v%0d_wr_cnt", i), a_wr_cnt, vecs[i].e_wr);
            @(posedge clk); #1;
        end

        // Abort: random backpressure, reset after two accepted words.
        a_oe = 0; a_wr = 1; a_addr = 16'h0000; a_ld_en = 1; a_ld_valid = 0;
        @(posedge clk); #1;
        acc = 0;
        saw_done = 0;
        for (int c = 0; c < 60 && acc < 2; c++) begin
            a_ld_valid = 1'($urandom_range(0, 1));
            a_ld_data  = 16'hA5A0 + 16'(acc);
            @(negedge clk);
            if (a_ld_done) saw_done = 1;
            rdy = a_ld_ready;
            @(posedge clk);
            if (rdy && a_ld_valid) acc++;
            #1;
        end
        chk("abort_accepts", 16'(acc), 16'd2);
        a_reset = 0; a_ld_valid = 0;
        @(negedge clk);
        if (a_ld_done) saw_done = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_bus_z",  a_bus, 16'hFFFF);
        chk("abort_count",  {7'd0, a_ld_count}, 16'd0);
        chk("abort_ready",  {15'd0, a_ld_ready}, 16'd0);
        chk("abort_rd_cnt", a_rd_cnt, 16'd0);
        @(posedge clk); #1;
        a_reset = 1; a_ld_en = 0; a_addr = 16'h0000;
        @(negedge clk);
        if (a_ld_done) saw_done = 1;
        chk("abort_mem0", a_bus, 16'hA5A0);
        @(posedge clk); #1;
        a_addr = 16'h0001;
        @(negedge clk);
        if (a_ld_done) saw_done = 1;
        chk("abort_mem1", a_bus, 16'hA5A1);
        chk("abort_no_done", {15'd0, saw_done}, 16'd0);
        @(posedge clk); #1;

        // Full boundary on the 4-word instance: offer 6 words.
        b_reset = 1; b_ld_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_ready_start", {15'd0, b_ld_ready}, 16'd1);
        @(posedge clk); #1;
        acc = 0;
        offered = 0;
        while (offered < 6) begin
            b_ld_valid = 1;
            b_ld_data  = 16'hC000 + 16'(acc);
            @(negedge clk);
            rdy = b_ld_ready;
            @(posedge clk);
            if (rdy) acc++;
            offered++;
            #1;
        end
        b_ld_valid = 0;
        @(negedge clk);
        chk("full_accepts", 16'(acc), 16'd4);
        chk("full_ready",   {15'd0, b_ld_ready}, 16'd0);
        chk("full_count",   {13'd0, b_ld_count}, 16'd4);
        @(posedge clk); #1;
        b_ld_en = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_done", {15'd0, b_ld_done}, 16'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            b_addr = 16'(k);
            @(negedge clk);
            chk($sformatf("full_mem%0d", k), b_bus, 16'hC000 + 16'(k));
            @(posedge clk); #1;
        end
        chk("full_count_hold", {13'd0, b_ld_count}, 16'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_memory.md
# bus_memory

Word-addressed memory responder for the CPU's external memory bus: it answers instruction fetches and data reads by driving the bidirectional 16-bit data bus, and captures CPU writes. It sits opposite the CPU top on `address_bus`/`data_bus`/`wr`. A host-side loader port preloads program images through a valid/ready handshake. Saturating access counters support bring-up and verification.

## Interface
- `ADDR_W`, 8: implemented address bits; depth = 2^ADDR_W words.
- `clk` in 1: system clock, shared with the CPU.
- `reset` in 1: synchronous, active-low reset.
- `address_bus` in 16: CPU word address. Only bits [ADDR_W-1:0] are used; upper bits are ignored (aliasing).
- `data_bus` inout 16: CPU data bus. This block drives it only while servicing a read; otherwise it is high-Z.
- `wr` in 1: CPU strobe. 1 = read, 0 = write.
- `ld_en` in 1: host requests load mode.
- `ld_valid` in 1: host load word valid.
- `ld_data` in 16: host load word.
- `ld_ready` out 1: block accepts a load word this cycle.
- `ld_done` out 1: one-cycle pulse when a load session ends.
- `ld_count` out ADDR_W+1: number of words written in the current or last load session.
- `rd_cnt` out 16: count of serviced CPU reads (saturating).
- `wr_cnt` out 16: count of accepted CPU writes (saturating).

## Operation
- FSM states: IDLE (serve CPU), LOAD (host loading), DONE (single cycle).
- Transitions:
  - IDLE to LOAD when `ld_en`=1 sampled at a clk edge; the load pointer clears to 0.
  - LOAD to DONE when `ld_en`=0 is sampled.
  - DONE to IDLE unconditionally.
- IDLE:
  - `wr`=1: drive `data_bus` = mem[address_bus[ADDR_W-1:0]] combinationally. `rd_cnt` increments at each clk edge where `wr`=1.
  - `wr`=0: release `data_bus`, and at the clk edge write mem[addr] <= `data_bus`. `wr_cnt` increments.
- LOAD:
  - `data_bus` is high-Z and CPU writes are ignored; counters hold.
  - `ld_ready` = 1 while the pointer is below depth.
  - On `ld_valid` & `ld_ready` at a clk edge: mem[ptr] <= `ld_data`, ptr++, and `ld_count` = ptr.
  - Full: once ptr reaches 2^ADDR_W, `ld_ready` = 0 and further words are refused; there is no wrap.
- DONE: `ld_done` = 1 for this cycle only. `data_bus` stays high-Z; `ld_count` holds until the next session starts.
- Counters saturate at 16'hFFFF.
- Reset (`reset`=0 at a clk edge), mid-load included:
  - state becomes IDLE; ptr, `ld_count`, `rd_cnt`, `wr_cnt` clear to 0; `ld_ready`=0 and `ld_done`=0.
  - No `ld_done` pulse is issued for an aborted session.
  - Memory contents are NOT cleared; words already loaded persist.
  - While `reset` is low, `data_bus` is high-Z.

## Timing
- Read latency: 0 cycles. Data is valid combinationally in the same cycle the address is presented with `wr`=1, so the CPU can latch it on the next edge.
- Write latency: 1 edge. A read of the same address in the following cycle returns the new value. A same-cycle read while `wr`=0 is not possible, because the bus is owned by the CPU.
- `ld_ready` is a registered function of state and ptr. Because it depends only on ptr, not on `ld_valid`, there is no combinational path from `ld_valid` to `ld_ready`.
- Simultaneous `ld_valid` accept and `ld_en` deassertion at the same edge: the word is written and the FSM moves to DONE.
- `ld_en` reasserted during DONE: the FSM enters IDLE first, then LOAD on the next edge (minimum 2-cycle gap between sessions).
- Tristate release and drive switch in the same cycle `wr` changes; there is no turnaround cycle.

## Test plan
- Reset: hold `reset`=0 for 2 edges, then release. Required: `data_bus`=Z, `ld_ready`=0, `ld_done`=0, counters=0, state IDLE.
- Load then read (`ADDR_W`=8): load 0x1111, 0x2222, 0x3333, then drop `ld_en`. Required: `ld_count`=3 and `ld_done` pulses exactly 1 cycle. Then `wr`=1 with address 0x0001 gives `data_bus`=0x2222; address 0x0101 (alias) also gives 0x2222.
- CPU write/read: `wr`=0 with address 0x0010 and data 0xBEEF for one edge, then `wr`=1. Required: `data_bus`=0xBEEF next cycle, `wr_cnt`=1, `rd_cnt` increments per read edge.
- Full boundary (`ADDR_W`=2): offer 6 words in LOAD. Required: 4 accepted, `ld_ready`=0 after the 4th, `ld_count`=4, and mem[0..3] hold the first four words.
- Backpressure/abort: toggle `ld_valid` randomly and assert `reset`=0 after 2 accepted words. Required: no `ld_done`, `ld_count`=0, mem[0..1] retain the loaded words, CPU read of address 0 returns word 0.
- Isolation: in LOAD, `wr`=0 with address 0x0000 and data 0xDEAD. Required: mem[0] unchanged, `data_bus` not driven by the block, `wr_cnt` unchanged.
